inst_fetch_unit: RTL and testbench



---
 rtl/inst_fetch_unit.sv | 114 +++++++++++
 tb/tb_inst_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ==== inst_fetch_unit: owns the PC, one outstanding imem read, valid/ready delivery, redirect squash ====
// ==== Optional FETCH_PERF_CNT_EN adds fetch_count / squash_count.                        Rev 1.0 ====
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  output logic        inst_valid,
  input  logic        inst_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] squash_count
`endif
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        capture;
  logic        unused_bits;

  assign unused_bits    = ^redirect_pc[1:0];
  assign imem_addr      = pc;
  assign imem_req_valid = (state == S_REQ);
  assign inst_valid     = (state == S_HOLD);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        // An accepted request still owes us a response, so a redirect must drain it.
        if (imem_req_ready) state_nxt = redirect_valid ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_nxt = redirect_valid ? S_REQ : S_HOLD;
          capture   = ~redirect_valid;
        end else if (redirect_valid) begin
          state_nxt = S_DROP;
        end
      end
      S_HOLD: begin
        if (redirect_valid || inst_ready) state_nxt = S_REQ;
      end
      S_DROP: begin
        if (imem_rsp_valid) state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (capture) pc_nxt = pc + STEP;
    if (redirect_valid) pc_nxt = {redirect_pc[31:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      inst      <= '0;
      inst_addr <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (capture) begin
        inst      <= imem_rsp_data;
        inst_addr <= pc;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // A held instruction taken in the same cycle as the redirect counts as delivered, not squashed.
  logic squash_evt;
  assign squash_evt = redirect_valid &&
                      ((state == S_WAIT) ||
                       (state == S_REQ  && imem_req_ready) ||
                       (state == S_HOLD && !inst_ready));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count  <= '0;
      squash_count <= '0;
    end else begin
      if (inst_valid && inst_ready) fetch_count  <= fetch_count + 32'd1;
      if (squash_evt)               squash_count <= squash_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ==== tb_inst_fetch_unit: directed stimulus, queue scoreboard for requests and delivered instructions. Rev 1.0 ====
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'hDEAD_BEEF;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] squash_count;
`endif

  inst_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst           (inst),
    .inst_addr      (inst_addr),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .squash_count   (squash_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [31:0] exp_req[$];
  logic [31:0] exp_data[$];
  logic [31:0] exp_iaddr[$];

  // memory model state
  bit          m_pend = 1'b0;
  int          m_cnt  = 0;
  logic [31:0] m_addr = 32'h0;
  int          mem_lat = 1;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accept decision is taken just before the edge, response appears after the next edge.
  task automatic tick();
    if (rst_n && imem_req_valid && imem_req_ready) begin
      if (m_pend) begin
        checks++;
        fails++;
        $display("FAIL outstanding: second request addr=%h while one is pending", imem_addr);
      end
      m_pend = 1'b1;
      m_cnt  = mem_lat;
      m_addr = imem_addr;
    end
    @(posedge clk);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    if (!rst_n) m_pend = 1'b0;
    if (m_pend) begin
      m_cnt--;
      if (m_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memdata(m_addr);
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!inst_valid && n < 20) begin
      tick();
      n++;
    end
    if (!inst_valid) begin
      checks++;
      fails++;
      $display("FAIL wait_valid: inst_valid=%b after %0d cycles, expected 1", inst_valid, n);
    end
  endtask

  // Starts in REQ at address a; delivers one instruction and returns in REQ.
  task automatic fetch_one(input logic [31:0] a, input logic [31:0] d);
    exp_req.push_back(a);
    exp_data.push_back(d);
    exp_iaddr.push_back(a);
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    wait_valid();
    tick();
    inst_ready = 1'b0;
  endtask

  // Monitor: samples mid-low-phase, pops expectations on each handshake.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && imem_req_valid && imem_req_ready) begin
        if (exp_req.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL req_unexpected: got addr %h expected no request", imem_addr);
        end else begin
          e = exp_req.pop_front();
          check("req_addr", imem_addr, e);
        end
      end
      if (rst_n && inst_valid && inst_ready) begin
        if (exp_data.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL inst_unexpected: got inst %h at %h expected none", inst, inst_addr);
        end else begin
          e = exp_data.pop_front();
          check("inst_data", inst, e);
          e = exp_iaddr.pop_front();
          check("inst_addr", inst_addr, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) tick();
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_addr", inst_addr, 32'h0);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);

    // first request one cycle after reset release
    rst_n = 1'b1;
    tick();
    check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_addr, 32'h0);
    fetch_one(32'h0, 32'h0050_0093);
    check("next_req_addr", imem_addr, 32'h4);

    // decoder stall in HOLD
    exp_req.push_back(32'h4);
    exp_data.push_back(32'h5A5A_0004);
    exp_iaddr.push_back(32'h4);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("hold_stable",
            {inst_valid, imem_req_valid, inst_addr[29:0]} ^ inst ^ 32'h0,
            {1'b1, 1'b0, 30'h4} ^ 32'h5A5A_0004);
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("after_stall_req", {imem_req_valid, imem_addr[30:0]}, {1'b1, 31'h8});

    // redirect while waiting for the response to 0x8
    exp_req.push_back(32'h8);
    mem_lat = 3;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("drop_no_req", {31'b0, imem_req_valid}, 32'd0);
    tick();
    tick();
    check("redir_req", {imem_req_valid, imem_addr[30:0]}, {1'b1, 31'h100});
    mem_lat = 1;
    fetch_one(32'h100, 32'h5A5A_0100);

    // redirect coinciding with the response
    exp_req.push_back(32'h104);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick();
    redirect_valid = 1'b0;
    check("rsp_redir_no_valid", {31'b0, inst_valid}, 32'd0);
    check("rsp_redir_req", {imem_req_valid, imem_addr[30:0]}, {1'b1, 31'h200});
    fetch_one(32'h200, 32'h5A5A_0200);

    // PC wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    fetch_one(32'hFFFF_FFFC, 32'hA5A5_FFFC);
    check("wrap_next_addr", imem_addr, 32'h0);

    // redirect while decoder stalls in HOLD
    exp_req.push_back(32'h0);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    wait_valid();
    check("hold_inst_pre_redir", inst, 32'h0050_0093);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("hold_redir_valid", {31'b0, inst_valid}, 32'd0);
    check("hold_redir_addr", imem_addr, 32'h40);
    fetch_one(32'h40, 32'h5A5A_0040);

`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, 32'd6);
    check("squash_count", squash_count, 32'd3);
`endif

    // reset while holding an instruction
    exp_req.push_back(32'h44);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    wait_valid();
    rst_n = 1'b0;
    tick();
    check("midrst_valid", {31'b0, inst_valid}, 32'd0);
    check("midrst_req", {31'b0, imem_req_valid}, 32'd0);
    check("midrst_inst", inst, 32'h0);
    rst_n = 1'b1;
    tick();
    check("midrst_restart", {imem_req_valid, imem_addr[30:0]}, {1'b1, 31'h0});
    fetch_one(32'h0, 32'h0050_0093);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count_after_rst", fetch_count, 32'd1);
    check("squash_count_after_rst", squash_count, 32'd0);
`endif

    tick();
    check("req_queue_empty", exp_req.size(), 32'd0);
    check("inst_queue_empty", exp_data.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
